// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: widths, op encodings,
// FSM states, stack-pointer update commands and an address range helper.
package mem_stage_ctrl_pkg;

    localparam int DATA_W        = 16;
    localparam int PC_W          = 32;
    localparam int TAG_W         = 3;
    localparam int ADDR_W        = 16;
    localparam int MEM_DEPTH_DEF = 2044;
    localparam int SP_INIT_DEF   = 2043;

    // EX/MEM op encodings
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_STORE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4,
        OP_CALL  = 3'd5,
        OP_RET   = 3'd6
    } op_e;

    // Controller FSM: SECOND is the second word access of CALL/RET
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    // Stack pointer update commands
    typedef enum logic [2:0] {
        SP_HOLD = 3'd0,
        SP_DEC1 = 3'd1,
        SP_DEC2 = 3'd2,
        SP_INC1 = 3'd3,
        SP_INC2 = 3'd4
    } sp_upd_e;

    // True when a data address lies inside the physical memory
    function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_sp_unit.sv
// Stack pointer unit: holds sp, provides the neighbour addresses used by the
// stack ops, applies update commands and flags overflow/underflow conditions.
module mem_stage_ctrl_sp_unit
    import mem_stage_ctrl_pkg::*;
#(
    parameter int SP_INIT = SP_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  sp_upd_e           upd,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_p1,
    output logic [ADDR_W-1:0] sp_p2,
    output logic [ADDR_W-1:0] sp_m1,
    output logic              push_ovf,
    output logic              call_ovf,
    output logic              pop_unf,
    output logic              ret_unf
);

    localparam logic [ADDR_W-1:0] SP_INIT_W   = ADDR_W'(SP_INIT);
    localparam logic [ADDR_W-1:0] RET_LIMIT_W = ADDR_W'(SP_INIT - 2);

    logic [ADDR_W-1:0] sp_r;
    logic [ADDR_W-1:0] sp_nxt_s;

    // Next stack pointer from the requested update (mod 2^16)
    always_comb begin
        sp_nxt_s = sp_r;
        case (upd)
            SP_HOLD: sp_nxt_s = sp_r;
            SP_DEC1: sp_nxt_s = sp_r - 16'd1;
            SP_DEC2: sp_nxt_s = sp_r - 16'd2;
            SP_INC1: sp_nxt_s = sp_r + 16'd1;
            SP_INC2: sp_nxt_s = sp_r + 16'd2;
            default: sp_nxt_s = sp_r;
        endcase
    end

    // Stack pointer register, restarts at the top of the stack on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r <= SP_INIT_W;
        end else begin
            sp_r <= sp_nxt_s;
        end
    end

    assign sp    = sp_r;
    assign sp_p1 = sp_r + 16'd1;
    assign sp_p2 = sp_r + 16'd2;
    assign sp_m1 = sp_r - 16'd1;

    // A PUSH needs one free word, a CALL two; POP/RET need stored words above sp
    assign push_ovf = (sp_r == 16'd0);
    assign call_ovf = (sp_r < 16'd2);
    assign pop_unf  = (sp_r >= SP_INIT_W);
    assign ret_unf  = (sp_r > RET_LIMIT_W);

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: decodes one EX/MEM op per cycle, drives the word
// memory ports, splits 32-bit PC push/pop into two accesses (stalling EX/MEM
// for one cycle) and registers load/pop/return results toward MEM/WB.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int SP_INIT   = SP_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [TAG_W-1:0]  rd_in,
    output logic              stall,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [TAG_W-1:0]  wb_rd,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_target,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_fault
);

    localparam logic [ADDR_W-1:0] MEM_DEPTH_W = ADDR_W'(MEM_DEPTH);

    state_e            state_r;
    state_e            state_nxt_s;
    logic              is_ret_r;
    logic              is_ret_nxt_s;
    logic [DATA_W-1:0] low_r;

    logic              stall_s;
    logic              mem_re_s;
    logic [ADDR_W-1:0] mem_raddr_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic              wb_set_s;
    logic              pc_set_s;
    logic              lat_low_s;
    logic              fault_set_s;
    sp_upd_e           sp_upd_s;

    logic [ADDR_W-1:0] sp_s;
    logic [ADDR_W-1:0] sp_p1_s;
    logic [ADDR_W-1:0] sp_p2_s;
    logic [ADDR_W-1:0] sp_m1_s;
    logic              push_ovf_s;
    logic              call_ovf_s;
    logic              pop_unf_s;
    logic              ret_unf_s;

    logic              wb_valid_r;
    logic [DATA_W-1:0] wb_data_r;
    logic [TAG_W-1:0]  wb_rd_r;
    logic              pc_load_r;
    logic [PC_W-1:0]   pc_target_r;
    logic              stack_fault_r;

    mem_stage_ctrl_sp_unit #(
        .SP_INIT (SP_INIT)
    ) u_sp_unit (
        .clk      (clk),
        .rst      (rst),
        .upd      (sp_upd_s),
        .sp       (sp_s),
        .sp_p1    (sp_p1_s),
        .sp_p2    (sp_p2_s),
        .sp_m1    (sp_m1_s),
        .push_ovf (push_ovf_s),
        .call_ovf (call_ovf_s),
        .pop_unf  (pop_unf_s),
        .ret_unf  (ret_unf_s)
    );

    // Op decode: memory port drive, stall, sp update and next FSM state.
    // Everything stays quiet while rst is high so a reset in SECOND aborts
    // the second CALL write.
    always_comb begin
        stall_s      = 1'b0;
        mem_re_s     = 1'b0;
        mem_raddr_s  = 16'd0;
        mem_we_s     = 1'b0;
        mem_waddr_s  = 16'd0;
        mem_wdata_s  = 16'd0;
        wb_set_s     = 1'b0;
        pc_set_s     = 1'b0;
        lat_low_s    = 1'b0;
        fault_set_s  = 1'b0;
        sp_upd_s     = SP_HOLD;
        state_nxt_s  = state_r;
        is_ret_nxt_s = is_ret_r;
        if (rst) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (op)
                            OP_LOAD: begin
                                if (addr_legal(alu_addr, MEM_DEPTH_W)) begin
                                    mem_re_s    = 1'b1;
                                    mem_raddr_s = alu_addr;
                                    wb_set_s    = 1'b1;
                                end else begin
                                    fault_set_s = 1'b1;
                                end
                            end
                            OP_STORE: begin
                                if (addr_legal(alu_addr, MEM_DEPTH_W)) begin
                                    mem_we_s    = 1'b1;
                                    mem_waddr_s = alu_addr;
                                    mem_wdata_s = store_data;
                                end else begin
                                    fault_set_s = 1'b1;
                                end
                            end
                            OP_PUSH: begin
                                if (push_ovf_s) begin
                                    fault_set_s = 1'b1;
                                end else begin
                                    mem_we_s    = 1'b1;
                                    mem_waddr_s = sp_s;
                                    mem_wdata_s = store_data;
                                    sp_upd_s    = SP_DEC1;
                                end
                            end
                            OP_POP: begin
                                if (pop_unf_s) begin
                                    fault_set_s = 1'b1;
                                end else begin
                                    mem_re_s    = 1'b1;
                                    mem_raddr_s = sp_p1_s;
                                    wb_set_s    = 1'b1;
                                    sp_upd_s    = SP_INC1;
                                end
                            end
                            OP_CALL: begin
                                if (call_ovf_s) begin
                                    fault_set_s = 1'b1;
                                end else begin
                                    mem_we_s     = 1'b1;
                                    mem_waddr_s  = sp_s;
                                    mem_wdata_s  = pc_in[31:16];
                                    stall_s      = 1'b1;
                                    is_ret_nxt_s = 1'b0;
                                    state_nxt_s  = ST_SECOND;
                                end
                            end
                            OP_RET: begin
                                if (ret_unf_s) begin
                                    fault_set_s = 1'b1;
                                end else begin
                                    mem_re_s     = 1'b1;
                                    mem_raddr_s  = sp_p1_s;
                                    lat_low_s    = 1'b1;
                                    stall_s      = 1'b1;
                                    is_ret_nxt_s = 1'b1;
                                    state_nxt_s  = ST_SECOND;
                                end
                            end
                            default: begin
                                state_nxt_s = ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SECOND: begin
                    // EX/MEM still holds the same op; only the second word remains
                    state_nxt_s = ST_IDLE;
                    if (is_ret_r) begin
                        mem_re_s    = 1'b1;
                        mem_raddr_s = sp_p2_s;
                        pc_set_s    = 1'b1;
                        sp_upd_s    = SP_INC2;
                    end else begin
                        mem_we_s    = 1'b1;
                        mem_waddr_s = sp_m1_s;
                        mem_wdata_s = pc_in[15:0];
                        sp_upd_s    = SP_DEC2;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, CALL/RET flavour of SECOND, and the latched low PC word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            is_ret_r <= 1'b0;
            low_r    <= 16'd0;
        end else begin
            state_r  <= state_nxt_s;
            is_ret_r <= is_ret_nxt_s;
            if (lat_low_s) begin
                low_r <= mem_rdata;
            end
        end
    end

    // MEM/WB result registers; wb_valid and pc_load are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_r    <= 1'b0;
            wb_data_r     <= 16'd0;
            wb_rd_r       <= 3'd0;
            pc_load_r     <= 1'b0;
            pc_target_r   <= 32'd0;
            stack_fault_r <= 1'b0;
        end else begin
            wb_valid_r <= wb_set_s;
            pc_load_r  <= pc_set_s;
            if (wb_set_s) begin
                wb_data_r <= mem_rdata;
                wb_rd_r   <= rd_in;
            end
            if (pc_set_s) begin
                pc_target_r <= {mem_rdata, low_r};
            end
            if (fault_set_s) begin
                stack_fault_r <= 1'b1;
            end
        end
    end

    assign stall       = stall_s;
    assign mem_re      = mem_re_s;
    assign mem_raddr   = mem_raddr_s;
    assign mem_we      = mem_we_s;
    assign mem_waddr   = mem_waddr_s;
    assign mem_wdata   = mem_wdata_s;
    assign wb_valid    = wb_valid_r;
    assign wb_data     = wb_data_r;
    assign wb_rd       = wb_rd_r;
    assign pc_load     = pc_load_r;
    assign pc_target   = pc_target_r;
    assign sp          = sp_s;
    assign stack_fault = stack_fault_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: a word memory model attached to the DUT ports,
// a behavioural stack/memory reference model that pushes expected write-back
// and PC-load results into queues, and a monitor that pops and compares them.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

    localparam int MEM_DEPTH = 2044;
    localparam int SP_INIT   = 2043;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] alu_addr = 16'd0;
    logic [15:0] store_data = 16'd0;
    logic [31:0] pc_in = 32'd0;
    logic [2:0]  rd_in = 3'd0;
    logic        stall;
    logic        mem_re;
    logic [15:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        mem_we;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [2:0]  wb_rd;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [15:0] sp;
    logic        stack_fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // physical memory attached to the DUT, and the reference model's view
    logic [15:0] tb_mem    [0:2047] = '{default: 16'h0000};
    logic [15:0] model_mem [0:2047] = '{default: 16'h0000};
    int          model_sp    = SP_INIT;
    bit          model_fault = 1'b0;

    typedef struct { logic [15:0] data; logic [2:0] rd; int cyc; } wb_exp_t;
    typedef struct { logic [31:0] pc; int cyc; } pc_exp_t;
    wb_exp_t wb_q[$];
    pc_exp_t pc_q[$];

    mem_stage_ctrl #(.MEM_DEPTH(MEM_DEPTH), .SP_INIT(SP_INIT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .alu_addr(alu_addr),
        .store_data(store_data), .pc_in(pc_in), .rd_in(rd_in), .stall(stall),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .pc_load(pc_load),
        .pc_target(pc_target), .sp(sp), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_we && mem_waddr < 16'd2048) tb_mem[mem_waddr[10:0]] <= mem_wdata;
    end
    assign mem_rdata = (mem_raddr < 16'd2048) ? tb_mem[mem_raddr[10:0]] : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: compare every presented result against the queued expectation
    always @(negedge clk) begin
        if (wb_valid) begin
            if (wb_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL wb_unexpected actual=%h expected=none (cycle %0d)", wb_data, cyc);
            end else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                chk("wb_data", {16'h0, wb_data}, {16'h0, e.data});
                chk("wb_rd", {29'h0, wb_rd}, {29'h0, e.rd});
                chk("wb_latency", cyc, e.cyc);
            end
        end
        if (pc_load) begin
            if (pc_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL pc_unexpected actual=%h expected=none (cycle %0d)", pc_target, cyc);
            end else begin
                pc_exp_t p;
                p = pc_q.pop_front();
                chk("pc_target", pc_target, p.pc);
                chk("pc_latency", cyc, p.cyc);
            end
        end
    end

    task automatic idle(input int k);
        in_valid = 1'b0;
        op = 3'd0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        op = 3'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_sp = SP_INIT;
        model_fault = 1'b0;
        @(negedge clk);
        chk("rst_comb_quiet", {29'h0, stall, mem_we, mem_re}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_sp", {16'h0, sp}, SP_INIT);
        chk("rst_fault", {31'h0, stack_fault}, 32'h0);
        chk("rst_pulses", {30'h0, wb_valid, pc_load}, 32'h0);
        chk("rst_wb_data", {13'h0, wb_rd, wb_data}, 32'h0);
        chk("rst_pc_target", pc_target, 32'h0);
        chk("idle_comb_quiet", {29'h0, stall, mem_we, mem_re}, 32'h0);
    endtask

    // issue one op and apply the reference rules to predict its effects
    task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] d,
                         input logic [31:0] p, input logic [2:0] r);
        bit fault = 1'b0;
        bit two   = 1'b0;
        int n     = cyc;
        in_valid = 1'b1; op = o; alu_addr = a; store_data = d; pc_in = p; rd_in = r;
        case (o)
            3'd1: if (a >= MEM_DEPTH) fault = 1'b1;
                  else wb_q.push_back('{model_mem[a], r, n + 1});
            3'd2: if (a >= MEM_DEPTH) fault = 1'b1;
                  else model_mem[a] = d;
            3'd3: if (model_sp == 0) fault = 1'b1;
                  else begin model_mem[model_sp] = d; model_sp = model_sp - 1; end
            3'd4: if (model_sp >= SP_INIT) fault = 1'b1;
                  else begin model_sp = model_sp + 1; wb_q.push_back('{model_mem[model_sp], r, n + 1}); end
            3'd5: if (model_sp < 2) fault = 1'b1;
                  else begin
                      model_mem[model_sp] = p[31:16];
                      model_mem[model_sp - 1] = p[15:0];
                      model_sp = model_sp - 2;
                      two = 1'b1;
                  end
            3'd6: if (model_sp > SP_INIT - 2) fault = 1'b1;
                  else begin
                      pc_q.push_back('{{model_mem[model_sp + 2], model_mem[model_sp + 1]}, n + 2});
                      model_sp = model_sp + 2;
                      two = 1'b1;
                  end
            default: ;
        endcase
        if (fault) model_fault = 1'b1;
        @(negedge clk);
        chk("stall", {31'h0, stall}, {31'h0, two});
        if (fault) chk("access_suppressed", {30'h0, mem_re, mem_we}, 32'h0);
        @(posedge clk);
        #1;
        if (two) begin
            @(negedge clk);
            chk("stall_second", {31'h0, stall}, 32'h0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        op = 3'd0;
        chk("sp", {16'h0, sp}, model_sp);
        chk("stack_fault", {31'h0, stack_fault}, {31'h0, model_fault});
    endtask

    initial begin
        int bad;
        do_reset();

        // store then load the same word
        issue(3'd2, 16'h0010, 16'h00A5, 32'h0, 3'd0);
        issue(3'd1, 16'h0010, 16'h0000, 32'h0, 3'd5);
        // boundary addresses
        issue(3'd2, 16'd2043, 16'h7E57, 32'h0, 3'd0);
        issue(3'd1, 16'd2043, 16'h0000, 32'h0, 3'd2);

        // push/pop ordering
        issue(3'd3, 16'h0, 16'h1234, 32'h0, 3'd0);
        issue(3'd3, 16'h0, 16'h5678, 32'h0, 3'd0);
        issue(3'd4, 16'h0, 16'h0, 32'h0, 3'd1);
        issue(3'd4, 16'h0, 16'h0, 32'h0, 3'd2);

        // call/return round trip
        issue(3'd5, 16'h0, 16'h0, 32'hDEAD_BEEF, 3'd0);
        chk("call_hi_word", {16'h0, tb_mem[2043]}, 32'h0000_DEAD);
        chk("call_lo_word", {16'h0, tb_mem[2042]}, 32'h0000_BEEF);
        issue(3'd6, 16'h0, 16'h0, 32'h0, 3'd0);

        // underflow at reset sp, fault is sticky
        issue(3'd4, 16'h0, 16'h0, 32'h0, 3'd3);
        idle(3);
        chk("fault_sticky", {31'h0, stack_fault}, 32'h1);
        issue(3'd3, 16'h0, 16'h4242, 32'h0, 3'd0);
        issue(3'd6, 16'h0, 16'h0, 32'h0, 3'd0);
        do_reset();

        // illegal data address
        issue(3'd1, 16'h0800, 16'h0, 32'h0, 3'd1);
        issue(3'd2, 16'd2044, 16'hBAD0, 32'h0, 3'd0);
        do_reset();

        // reset while CALL is in its second cycle
        in_valid = 1'b1; op = 3'd5; pc_in = 32'hCAFE_F00D;
        model_mem[SP_INIT] = 16'hCAFE;
        @(negedge clk);
        chk("call_stall", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_second_quiet", {29'h0, stall, mem_we, mem_re}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; op = 3'd0;
        model_sp = SP_INIT; model_fault = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_sp", {16'h0, sp}, SP_INIT);
        chk("abort_hi_kept", {16'h0, tb_mem[2043]}, {16'h0, model_mem[2043]});
        chk("abort_no_lo", {16'h0, tb_mem[2042]}, {16'h0, model_mem[2042]});
        issue(3'd6, 16'h0, 16'h0, 32'h0, 3'd0);
        do_reset();

        // fill the stack to the bottom and probe overflow
        while (model_sp > 1) issue(3'd3, 16'h0, 16'($urandom), 32'h0, 3'd0);
        issue(3'd5, 16'h0, 16'h0, 32'h1111_2222, 3'd0);
        issue(3'd3, 16'h0, 16'hAAAA, 32'h0, 3'd0);
        issue(3'd3, 16'h0, 16'hBBBB, 32'h0, 3'd0);
        issue(3'd4, 16'h0, 16'h0, 32'h0, 3'd6);
        issue(3'd4, 16'h0, 16'h0, 32'h0, 3'd7);
        do_reset();
        issue(3'd3, 16'h0, 16'h0001, 32'h0, 3'd0);
        issue(3'd6, 16'h0, 16'h0, 32'h0, 3'd0);
        do_reset();

        // randomized mix
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  o;
            logic [15:0] a;
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = 16'($urandom_range(0, 15));
                1: a = 16'($urandom_range(2030, 2050));
                2: a = 16'h0800;
                default: a = 16'($urandom_range(0, 2043));
            endcase
            issue(o, a, 16'($urandom), $urandom, 3'($urandom));
            if ($urandom_range(0, 4) == 0) idle(1);
            if (i % 100 == 99) do_reset();
        end

        idle(3);
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("pc_queue_drained", pc_q.size(), 0);
        bad = 0;
        for (int k = 0; k < 2048; k++) if (tb_mem[k] !== model_mem[k]) bad++;
        chk("memory_image", bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
